// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives ROM address from fetch PC, buffers {pc,instr} in a prefetch FIFO.
// Latency: pushed word visible one cycle later; a full FIFO blocks fetch unless decode pops the same cycle.
module fetch_ctrl #(
   parameter int             N        = 32,
   parameter int             DEPTH    = 2,
   parameter logic [N-1:0]   RESET_PC = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [N-1:0] pc_out,
   input  logic [N-1:0] instr_in,
   input  logic         redirect_valid,
   input  logic [N-1:0] redirect_pc,
   output logic         out_valid,
   output logic [N-1:0] out_instr,
   output logic [N-1:0] out_pc,
   input  logic         out_ready,
   output logic         halted,
   output logic [N-1:0] fetch_pc
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] HALTED = 2'd2;

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [N-1:0]  fpc;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [N-1:0]  mem_pc    [DEPTH];
   logic [N-1:0]  mem_instr [DEPTH];

   logic pop;
   logic space;
   logic try_fetch;
   logic push;
   logic zero_hit;

   assign pc_out    = fpc;
   assign fetch_pc  = fpc;
   assign halted    = (state == HALTED);
   assign out_valid = (count != '0);
   assign out_instr = out_valid ? mem_instr[rd_ptr] : '0;
   assign out_pc    = out_valid ? mem_pc[rd_ptr]    : '0;

   // A pop in the same cycle frees the slot the push needs.
   assign pop       = out_valid & out_ready;
   assign space     = (count < CW'(DEPTH)) | pop;
   assign try_fetch = (state == RUN) & en & space & ~redirect_valid;
   assign push      = try_fetch & (|instr_in);
   assign zero_hit  = try_fetch & ~(|instr_in);

   always_comb begin
      state_nxt = state;
      if (redirect_valid) begin
         state_nxt = en ? RUN : IDLE;
      end else begin
         case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN: begin
               if (zero_hit)  state_nxt = HALTED;
               else if (!en)  state_nxt = IDLE;
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         fpc   <= RESET_PC;
      end else begin
         state <= state_nxt;
         if (redirect_valid)
            fpc <= {redirect_pc[N-1:2], 2'b00};
         else if (push)
            fpc <= fpc + N'(4);
      end
   end

   // Redirect flushes the queue and discards any pop/push of the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_ptr]    <= fpc;
         mem_instr[wr_ptr] <= instr_in;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized and directed bench for fetch_ctrl against a queue-based reference model.
module tb_fetch_ctrl;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] pc_out;
   logic [31:0] instr_in;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_ready;
   logic        halted;
   logic [31:0] fetch_pc;

   int errors = 0;
   int checks = 0;

   logic [31:0] rom [64];
   logic [63:0] q [$];
   int          mst;
   logic [31:0] mfpc;

   always #5 clk = ~clk;

   fetch_ctrl #(.N(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .en(en), .pc_out(pc_out), .instr_in(instr_in),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
      .out_ready(out_ready), .halted(halted), .fetch_pc(fetch_pc)
   );

   function automatic logic [31:0] romw(input logic [31:0] a);
      if (a[31:8] != 24'h0) return 32'h0;
      return rom[a[7:2]];
   endfunction

   assign instr_in = romw(pc_out);

   logic [129:0] obs;
   assign obs = {out_valid, halted, out_pc, out_instr, fetch_pc, pc_out};

   function automatic logic [129:0] expv();
      logic        v;
      logic [31:0] p;
      logic [31:0] w;
      v = (q.size() != 0);
      p = v ? q[0][63:32] : 32'h0;
      w = v ? q[0][31:0]  : 32'h0;
      return {v, (mst == 2), p, w, mfpc, mfpc};
   endfunction

   task automatic mreset();
      q.delete();
      mst  = 0;
      mfpc = 32'h0;
   endtask

   // Model: mst 0=idle, 1=running, 2=halted on zero word.
   task automatic step();
      int          s;
      bit          pop;
      bit          space;
      logic [31:0] w;
      if (rst) begin
         mreset();
      end else begin
         s   = mst;
         pop = (q.size() != 0) && out_ready;
         if (redirect_valid) begin
            q.delete();
            mfpc = {redirect_pc[31:2], 2'b00};
            mst  = en ? 1 : 0;
         end else begin
            w     = romw(mfpc);
            space = (q.size() < DEPTH) || pop;
            if (pop) void'(q.pop_front());
            if (s == 1 && en && space) begin
               if (w != 32'h0) begin
                  q.push_back({mfpc, w});
                  mfpc = mfpc + 32'd4;
               end else begin
                  mst = 2;
               end
            end
            if (s == 0 && en)  mst = 1;
            if (s == 1 && !en) mst = 0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en = 1'b0;
      out_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      #2;
      mreset();
      checks++;
      if (obs !== 130'h0) begin
         errors++;
         $display("FAIL reset_state got=%h exp=%h", obs, 130'h0);
      end
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (obs !== expv()) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, obs, expv());
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_stream();
      do_reset();
      en = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (obs !== expv()) begin
            errors++;
            $display("FAIL stream cyc=%0d got=%h exp=%h", i, obs, expv());
         end
         if (i == 1) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h00200393) begin
               errors++;
               $display("FAIL stream_first got v=%b pc=%h i=%h exp v=1 pc=0 i=00200393", out_valid, out_pc, out_instr);
            end
         end
      end
      checks++;
      if (fetch_pc !== 32'h18 || halted !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_end got fpc=%h h=%b v=%b exp fpc=18 h=1 v=0", fetch_pc, halted, out_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] acc [$];
      do_reset();
      en = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (obs !== expv()) begin
            errors++;
            $display("FAIL bp_stall cyc=%0d got=%h exp=%h", i, obs, expv());
         end
      end
      checks++;
      if (fetch_pc !== 32'h8 || out_pc !== 32'h0 || out_instr !== 32'h00200393) begin
         errors++;
         $display("FAIL bp_hold got fpc=%h pc=%h i=%h exp fpc=8 pc=0 i=00200393", fetch_pc, out_pc, out_instr);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (out_valid) acc.push_back(out_pc);
         step();
         checks++;
         if (obs !== expv()) begin
            errors++;
            $display("FAIL bp_drain cyc=%0d got=%h exp=%h", i, obs, expv());
         end
      end
      checks++;
      if (acc.size() != 6) begin
         errors++;
         $display("FAIL bp_count got=%0d exp=6", acc.size());
      end
      for (int i = 0; i < acc.size(); i++) begin
         checks++;
         if (acc[i] !== 32'(i * 4)) begin
            errors++;
            $display("FAIL bp_seq idx=%0d got=%h exp=%h", i, acc[i], 32'(i * 4));
         end
      end
   endtask

   task automatic test_redirect();
      logic [31:0] acc [$];
      do_reset();
      en = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 4; i++) step();
      out_ready = 1'b1;
      step();
      checks++;
      if (out_pc !== 32'h4 || fetch_pc !== 32'hC) begin
         errors++;
         $display("FAIL redir_pre got pc=%h fpc=%h exp pc=4 fpc=c", out_pc, fetch_pc);
      end
      redirect_valid = 1'b1; redirect_pc = 32'hC;
      step();
      redirect_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || fetch_pc !== 32'hC) begin
         errors++;
         $display("FAIL redir_flush got v=%b fpc=%h exp v=0 fpc=c", out_valid, fetch_pc);
      end
      for (int i = 0; i < 6; i++) begin
         if (out_valid) acc.push_back(out_pc);
         step();
         checks++;
         if (obs !== expv()) begin
            errors++;
            $display("FAIL redir cyc=%0d got=%h exp=%h", i, obs, expv());
         end
      end
      checks++;
      if (acc.size() != 3 || acc[0] !== 32'hC || acc[1] !== 32'h10 || acc[2] !== 32'h14) begin
         errors++;
         $display("FAIL redir_seq got n=%0d first=%h exp n=3 c,10,14", acc.size(), (acc.size() != 0) ? acc[0] : 32'hx);
      end
   endtask

   task automatic test_halt_redirect();
      do_reset();
      en = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 10; i++) step();
      redirect_valid = 1'b1; redirect_pc = 32'hE;
      step();
      redirect_valid = 1'b0;
      checks++;
      if (fetch_pc !== 32'hC || halted !== 1'b0) begin
         errors++;
         $display("FAIL halt_redir got fpc=%h h=%b exp fpc=c h=0", fetch_pc, halted);
      end
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (obs !== expv()) begin
            errors++;
            $display("FAIL halt_replay cyc=%0d got=%h exp=%h", i, obs, expv());
         end
      end
      en = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h0;
      step();
      redirect_valid = 1'b0;
      checks++;
      if (fetch_pc !== 32'h0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL halt_idle got fpc=%h h=%b exp fpc=0 h=0", fetch_pc, halted);
      end
      en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (obs !== expv()) begin
            errors++;
            $display("FAIL halt_restart cyc=%0d got=%h exp=%h", i, obs, expv());
         end
      end
   endtask

   task automatic test_en_drop();
      do_reset();
      en = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (obs !== expv()) begin
            errors++;
            $display("FAIL en_drop cyc=%0d got=%h exp=%h", i, obs, expv());
         end
      end
      checks++;
      if (fetch_pc !== 32'h8 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL en_frozen got fpc=%h v=%b exp fpc=8 v=0", fetch_pc, out_valid);
      end
      en = 1'b1;
      for (int i = 0; i < 2; i++) step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h8) begin
         errors++;
         $display("FAIL en_resume got v=%b pc=%h exp v=1 pc=8", out_valid, out_pc);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      en = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 4; i++) step();
      #2 rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || pc_out !== 32'h0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL async_rst got v=%b pc=%h h=%b exp v=0 pc=0 h=0", out_valid, pc_out, halted);
      end
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (obs !== expv()) begin
            errors++;
            $display("FAIL async_restart cyc=%0d got=%h exp=%h", i, obs, expv());
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         en             = ($urandom % 8) != 0;
         out_ready      = ($urandom % 4) != 0;
         redirect_valid = ($urandom % 16) == 0;
         redirect_pc    = $urandom % 32'h80;
         step();
         checks++;
         if (obs !== expv()) begin
            errors++;
            $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, expv());
         end
      end
      redirect_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 32'h0;
      rom[0] = 32'h00200393;
      rom[1] = 32'h00A00413;
      rom[2] = 32'h0083F533;
      rom[3] = 32'h00850593;
      rom[4] = 32'h40B40633;
      rom[5] = 32'h00C02023;
      for (int i = 7; i < 16; i++) rom[i] = $urandom | 32'h1;

      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_halt_redirect();
      test_en_drop();
      test_async_reset();
      test_random();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
